// File: rtl/simple_multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core sharing one memory port for fetch and data.
// Latency: R-type/addi/sw 4 cycles, lw 5, beq/j 3, plus one per memory wait cycle.
// Backpressure: FETCH and MEM hold the request steady until mem_ready_i is seen.
module simple_multi_cycle_cpu #(
  parameter int                DATA_W   = 32,
  parameter int                REG_NUM  = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i,
  output logic [DATA_W-1:0] pc_o,
  output logic              halt_o
);
  localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic [DATA_W-1:0] tgt_q, tgt_d, mdr_q, mdr_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [REG_NUM];

  logic              mem_req;
  logic              rf_we;
  logic [IDX_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // Instruction fields; register indices keep only the low IDX_W bits.
  logic [5:0]        op, funct;
  logic [IDX_W-1:0]  rs_idx, rt_idx, rd_idx;
  logic [DATA_W-1:0] imm_sext, rs_val, rt_val, r_res;
  logic              legal;

  assign op       = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rs_idx   = ir_q[21 +: IDX_W];
  assign rt_idx   = ir_q[16 +: IDX_W];
  assign rd_idx   = ir_q[11 +: IDX_W];
  assign imm_sext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
  assign rs_val   = (rs_idx == '0) ? '0 : regs_q[rs_idx];
  assign rt_val   = (rt_idx == '0) ? '0 : regs_q[rt_idx];

  // Opcode/funct legality check used by DECODE.
  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                        (funct == FN_OR)  || (funct == FN_SLT);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // R-type ALU on the operands latched in DECODE.
  always_comb begin
    r_res = '0;
    case (funct)
      FN_ADD:  r_res = a_q + b_q;
      FN_SUB:  r_res = a_q - b_q;
      FN_AND:  r_res = a_q & b_q;
      FN_OR:   r_res = a_q | b_q;
      FN_SLT:  r_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: r_res = '0;
    endcase
  end

  // Next-state, datapath next values and memory/regfile controls.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_d       = alu_q;
    tgt_d       = tgt_q;
    mem_req     = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = pc_q;
    mem_wdata_o = b_q;
    rf_we       = 1'b0;
    rf_waddr    = rt_idx;
    rf_wdata    = alu_q;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready_i) begin
          ir_d    = mem_rdata_i[31:0];
          pc_d    = pc_q + DATA_W'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rs_val;
        b_d     = rt_val;
        tgt_d   = pc_q + (imm_sext << 2);
        state_d = legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        case (op)
          OP_RTYPE: begin alu_d = r_res;          state_d = S_WB;  end
          OP_ADDI:  begin alu_d = a_q + imm_sext; state_d = S_WB;  end
          OP_LW, OP_SW: begin alu_d = a_q + imm_sext; state_d = S_MEM; end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = tgt_q;
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = {pc_q[DATA_W-1:28], ir_q[25:0], 2'b00};
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req    = 1'b1;
        mem_we_o   = (op == OP_SW);
        mem_addr_o = alu_q;
        if (mem_ready_i) begin
          if (op == OP_SW) begin
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata_i;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (op == OP_RTYPE) ? rd_idx : rt_idx;
        rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
        state_d  = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Reset must silence the port combinationally, before any clock edge.
  assign mem_req_o = mem_req & rst_i;
  assign pc_o      = pc_q;
  assign halt_o    = (state_q == S_HALT);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mdr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      tgt_q   <= tgt_d;
    end
  end

  // Register file; writes to register 0 are dropped.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (rf_we && (rf_waddr != '0)) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end
endmodule

// File: tb/tb_simple_multi_cycle_cpu.sv
// Directed bench for simple_multi_cycle_cpu: vector table plus multi-cycle sequences.
// Memory model with programmable wait states; second core instance at DATA_W=64, REG_NUM=8.
// Stores are logged and compared against hand-computed values.
module tb_simple_multi_cycle_cpu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ready, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  logic        rst64_n = 1'b0;
  logic        req64, we64, ready64, halt64;
  logic [63:0] addr64, wdata64, rdata64, pc64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  simple_multi_cycle_cpu dut (
    .clk_i(clk), .rst_i(rst_n), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .mem_ready_i(mem_ready), .pc_o(pc), .halt_o(halt));

  simple_multi_cycle_cpu #(.DATA_W(64), .REG_NUM(8), .RESET_PC(64'h0)) dut64 (
    .clk_i(clk), .rst_i(rst64_n), .mem_req_o(req64), .mem_we_o(we64),
    .mem_addr_o(addr64), .mem_wdata_o(wdata64), .mem_rdata_i(rdata64),
    .mem_ready_i(ready64), .pc_o(pc64), .halt_o(halt64));

  // 32-bit memory: reloaded from prog while reset is low, wait_n stall cycles per access.
  logic [31:0] prog [0:255];
  logic [31:0] mem  [0:255];
  int          wait_n = 0;
  int          cnt, wr_cnt, unstable;
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];
  logic        prev_pend, prev_we;
  logic [31:0] prev_addr, prev_wdata;

  assign mem_ready = mem_req && (cnt == wait_n);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 256; k++) mem[k] <= prog[k];
      cnt <= 0; wr_cnt <= 0; unstable <= 0; prev_pend <= 1'b0;
    end else begin
      if (prev_pend && (!mem_req || mem_addr != prev_addr || mem_we != prev_we ||
                        (mem_we && mem_wdata != prev_wdata)))
        unstable <= unstable + 1;
      prev_pend  <= mem_req && !mem_ready;
      prev_addr  <= mem_addr;
      prev_we    <= mem_we;
      prev_wdata <= mem_wdata;
      if (mem_req && mem_ready) begin
        cnt <= 0;
        if (mem_we) begin
          mem[mem_addr[9:2]] <= mem_wdata;
          if (wr_cnt < 8) begin
            wr_addr[wr_cnt[2:0]] <= mem_addr;
            wr_data[wr_cnt[2:0]] <= mem_wdata;
          end
          wr_cnt <= wr_cnt + 1;
        end
      end else if (mem_req) begin
        cnt <= cnt + 1;
      end else begin
        cnt <= 0;
      end
    end
  end

  // 64-bit core memory: instruction ROM, zero wait, stores logged only.
  logic [31:0] prog64 [0:63];
  int          wr64_cnt;
  logic [63:0] wr64_addr [0:3];
  logic [63:0] wr64_data [0:3];

  assign ready64 = req64;
  assign rdata64 = {32'h0, prog64[addr64[7:2]]};

  always @(posedge clk or negedge rst64_n) begin
    if (!rst64_n) begin
      wr64_cnt <= 0;
    end else if (req64 && ready64 && we64) begin
      if (wr64_cnt < 4) begin
        wr64_addr[wr64_cnt[1:0]] <= addr64;
        wr64_data[wr64_cnt[1:0]] <= wdata64;
      end
      wr64_cnt <= wr64_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] i0, i1, i2;
    logic [31:0] exp;
    int          cyc;
  } vec_t;
  vec_t vecs [10];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(input int tgt);
    return {6'h02, tgt[25:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int k = 0; k < 256; k++) prog[k] = 32'h0;
    prog[16] = 32'h1234_5678;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int cyc);
    cyc = 0;
    while (!halt && cyc < budget) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  initial begin
    int cyc;
    int req_seen;

    vecs[0] = '{enc_i(6'h08,0,1,5),      enc_i(6'h08,0,2,-3),    enc_r(1,2,3,6'h20), 32'h0000_0002, 18};
    vecs[1] = '{enc_i(6'h08,0,1,5),      enc_i(6'h08,0,2,-3),    enc_r(1,2,3,6'h22), 32'h0000_0008, 18};
    vecs[2] = '{enc_i(6'h08,0,1,'h0F0F), enc_i(6'h08,0,2,'h00FF), enc_r(1,2,3,6'h24), 32'h0000_000F, 18};
    vecs[3] = '{enc_i(6'h08,0,1,'h0F0F), enc_i(6'h08,0,2,'h00FF), enc_r(1,2,3,6'h25), 32'h0000_0FFF, 18};
    vecs[4] = '{enc_i(6'h08,0,1,-3),     enc_i(6'h08,0,2,5),     enc_r(1,2,3,6'h2A), 32'h0000_0001, 18};
    vecs[5] = '{enc_i(6'h08,0,1,5),      enc_i(6'h08,0,2,-3),    enc_r(1,2,3,6'h2A), 32'h0000_0000, 18};
    vecs[6] = '{enc_i(6'h08,0,0,7),      enc_i(6'h08,0,1,1),     enc_r(0,0,3,6'h20), 32'h0000_0000, 18};
    vecs[7] = '{enc_i(6'h23,0,1,'h40),   enc_i(6'h08,0,2,1),     enc_r(1,2,3,6'h20), 32'h1234_5679, 19};
    vecs[8] = '{enc_i(6'h08,0,1,'h7FFF), enc_i(6'h08,0,2,-1),    enc_r(1,2,3,6'h20), 32'h0000_7FFE, 18};
    vecs[9] = '{enc_i(6'h08,0,1,1),      enc_i(6'h08,0,2,0),     enc_r(0,1,3,6'h22), 32'hFFFF_FFFF, 18};

    for (int k = 0; k < 64; k++) prog64[k] = 32'h0;
    prog64[0] = enc_i(6'h08,0,9,-1);
    prog64[1] = enc_i(6'h08,0,2,1);
    prog64[2] = enc_r(0,2,3,6'h22);
    prog64[3] = enc_i(6'h2B,0,1,'h80);
    prog64[4] = enc_i(6'h2B,0,3,'h88);

    // Reset state
    clear_prog();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req", 64'(mem_req), 64'd0);
    check("reset_pc", 64'(pc), 64'd0);
    check("reset_halt", 64'(halt), 64'd0);

    // Vector table: three ops, store $3 to 0x80, then illegal word 0
    for (int v = 0; v < 10; v++) begin
      clear_prog();
      wait_n  = 0;
      prog[0] = vecs[v].i0;
      prog[1] = vecs[v].i1;
      prog[2] = vecs[v].i2;
      prog[3] = enc_i(6'h2B,0,3,'h80);
      do_reset();
      run_to_halt(200, cyc);
      check($sformatf("v%0d_halt", v), 64'(halt), 64'd1);
      check($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vecs[v].cyc));
      check($sformatf("v%0d_wrcnt", v), 64'(wr_cnt), 64'd1);
      check($sformatf("v%0d_wraddr", v), 64'(wr_addr[0]), 64'h80);
      check($sformatf("v%0d_wrdata", v), 64'(wr_data[0]), 64'(vecs[v].exp));
      check($sformatf("v%0d_pc", v), 64'(pc), 64'h14);
    end

    // Three-instruction timing: state after exactly 12 cycles
    clear_prog();
    wait_n  = 0;
    prog[0] = 32'h2001_0005;
    prog[1] = enc_i(6'h08,0,2,-3);
    prog[2] = enc_r(1,2,3,6'h20);
    do_reset();
    repeat (12) @(posedge clk);
    #1;
    check("c12_pc", 64'(pc), 64'd12);
    check("c12_fetch_req", 64'(mem_req), 64'd1);
    check("c12_fetch_addr", 64'(mem_addr), 64'd12);
    check("c12_r3", 64'(dut.regs_q[3]), 64'd2);

    // sw/lw with 3 wait cycles on every access
    clear_prog();
    wait_n  = 3;
    prog[0] = enc_i(6'h08,0,1,5);
    prog[1] = enc_i(6'h2B,0,1,16);
    prog[2] = enc_i(6'h23,0,4,16);
    prog[3] = enc_i(6'h2B,0,4,'h84);
    do_reset();
    run_to_halt(300, cyc);
    check("ws_halt", 64'(halt), 64'd1);
    check("ws_cycles", 64'(cyc), 64'd43);
    check("ws_wrcnt", 64'(wr_cnt), 64'd2);
    check("ws_wraddr0", 64'(wr_addr[0]), 64'd16);
    check("ws_wrdata0", 64'(wr_data[0]), 64'd5);
    check("ws_wraddr1", 64'(wr_addr[1]), 64'h84);
    check("ws_wrdata1", 64'(wr_data[1]), 64'd5);
    check("ws_r4", 64'(dut.regs_q[4]), 64'd5);
    check("ws_stable", 64'(unstable), 64'd0);

    // beq to itself at 0x20 loops every 3 cycles
    clear_prog();
    wait_n  = 0;
    prog[0] = enc_i(6'h08,0,1,5);
    prog[1] = enc_i(6'h08,0,2,6);
    prog[2] = enc_j(8);
    prog[8] = enc_i(6'h04,1,1,-1);
    do_reset();
    repeat (11) @(posedge clk);
    #1;
    check("loop_entry_pc", 64'(pc), 64'h20);
    check("loop_entry_addr", 64'(mem_req ? mem_addr : 32'hDEAD_BEEF), 64'h20);
    for (int it = 0; it < 3; it++) begin
      @(posedge clk); #1;
      check($sformatf("loop%0d_pc_inc", it), 64'(pc), 64'h24);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("loop%0d_pc", it), 64'(pc), 64'h20);
      check($sformatf("loop%0d_addr", it), 64'(mem_req ? mem_addr : 32'hDEAD_BEEF), 64'h20);
    end

    // beq with unequal operands falls through to 0x24
    prog[8] = enc_i(6'h04,1,2,-1);
    do_reset();
    run_to_halt(200, cyc);
    check("bne_halt", 64'(halt), 64'd1);
    check("bne_cycles", 64'(cyc), 64'd16);
    check("bne_pc", 64'(pc), 64'h28);

    // j 0x40 from address 0 fetches 0x100 next
    clear_prog();
    prog[0] = enc_j('h40);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("j_fetch_addr", 64'(mem_req ? mem_addr : 32'hDEAD_BEEF), 64'h100);
    run_to_halt(50, cyc);
    check("j_halt_pc", 64'(pc), 64'h104);

    // Illegal opcode 0x3F at 0x8: halts and stays quiet
    clear_prog();
    prog[0] = enc_i(6'h08,0,1,5);
    prog[1] = enc_i(6'h08,0,2,6);
    prog[2] = 32'hFC00_0000;
    do_reset();
    run_to_halt(100, cyc);
    check("ill_halt", 64'(halt), 64'd1);
    check("ill_cycles", 64'(cyc), 64'd10);
    check("ill_pc", 64'(pc), 64'hC);
    req_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (mem_req) req_seen++;
    end
    check("ill_quiet_req", 64'(req_seen), 64'd0);
    check("ill_pc_hold", 64'(pc), 64'hC);
    check("ill_halt_hold", 64'(halt), 64'd1);

    // Reset pulsed during a lw wait
    clear_prog();
    wait_n  = 3;
    prog[0] = enc_i(6'h08,0,1,5);
    prog[1] = enc_i(6'h23,0,1,'h40);
    do_reset();
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("mid_lw_pending", 64'(mem_req ? mem_addr : 32'hDEAD_BEEF), 64'h40);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 64'(mem_req), 64'd0);
    check("mid_rst_pc", 64'(pc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_req", 64'(mem_req), 64'd1);
    check("post_rst_we", 64'(mem_we), 64'd0);
    check("post_rst_addr", 64'(mem_addr), 64'd0);
    check("post_rst_r1", 64'(dut.regs_q[1]), 64'd0);
    check("post_rst_wrcnt", 64'(wr_cnt), 64'd0);
    wait_n = 0;

    // 64-bit, 8-register instance: index wrap and modulo-2^64 subtract
    @(negedge clk); rst64_n = 1'b0;
    @(negedge clk); rst64_n = 1'b1;
    cyc = 0;
    while (!halt64 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check("w64_halt", 64'(halt64), 64'd1);
    check("w64_cycles", 64'(cyc), 64'd22);
    check("w64_wrcnt", 64'(wr64_cnt), 64'd2);
    check("w64_r1_addr", wr64_addr[0], 64'h80);
    check("w64_r1_data", wr64_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
    check("w64_sub_addr", wr64_addr[1], 64'h88);
    check("w64_sub_data", wr64_data[1], 64'hFFFF_FFFF_FFFF_FFFF);
    check("w64_pc", pc64, 64'h18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
